// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i fetch front end: PC owner, single-outstanding imem reads, decode FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        decode_ready,
  input  logic        redirect_enable,
  input  logic [31:0] redirect_pc,
  output logic        misaligned_fault
);

  typedef enum logic [1:0] {S_FETCH, S_FLUSH, S_HALT} state_e;

  localparam logic [2:0] DEPTH_C  = 3'(FIFO_DEPTH);
  localparam logic [1:0] LAST_IDX = 2'(FIFO_DEPTH - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic        fault_q, fault_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] pc_mem_q  [0:3];
  logic [31:0] ins_mem_q [0:3];
  logic        push, pop, aligned;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  assign imem_req          = req_q;
  assign imem_addr         = addr_q;
  assign instruction       = ins_mem_q[rd_ptr_q];
  assign instruction_pc    = pc_mem_q[rd_ptr_q];
  assign instruction_valid = (count_q != 3'd0);
  assign misaligned_fault  = fault_q;
  assign aligned           = (redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fault_d     = fault_q;
    halt_pend_d = halt_pend_q;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect_enable) begin
          // Redirect beats push/pop; a coinciding ack is dropped with the flush.
          count_d  = 3'd0;
          rd_ptr_d = 2'd0;
          wr_ptr_d = 2'd0;
          if (aligned) begin
            pc_d = redirect_pc;
            if (req_q && !imem_ack) begin
              state_d = S_FLUSH;
            end else begin
              req_d  = 1'b1;
              addr_d = redirect_pc;
            end
          end else begin
            fault_d = 1'b1;
            if (req_q && !imem_ack) begin
              state_d     = S_FLUSH;
              halt_pend_d = 1'b1;
            end else begin
              state_d = S_HALT;
              req_d   = 1'b0;
            end
          end
        end else begin
          push    = req_q & imem_ack;
          pop     = instruction_valid & decode_ready;
          count_d = count_q + {2'b00, push} - {2'b00, pop};
          if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            pc_d     = pc_q + 32'd4;
          end
          if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
          end
          // Address and request only move once the current request is acked.
          if (!req_q || imem_ack) begin
            req_d  = (count_d < DEPTH_C);
            addr_d = pc_d;
          end
        end
      end
      S_FLUSH: begin
        if (redirect_enable && !halt_pend_q) begin
          if (aligned) begin
            pc_d = redirect_pc;
          end else begin
            fault_d     = 1'b1;
            halt_pend_d = 1'b1;
          end
        end
        if (imem_ack) begin
          if (halt_pend_d) begin
            state_d = S_HALT;
            req_d   = 1'b0;
          end else begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_d;
          end
        end
      end
      S_HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = S_HALT;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      count_q     <= 3'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pc_mem_q[i]  <= 32'd0;
        ins_mem_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]  <= addr_q;
        ins_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        decode_ready = 1'b0;
  logic        redirect_enable = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        misaligned_fault;

  int passed = 0;
  int total  = 0;
  int mem_delay = 0;
  int wait_cnt  = 0;
  int ack_count = 0;
  logic [31:0] exp_q [$];

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .instruction_valid(instruction_valid),
    .decode_ready     (decode_ready),
    .redirect_enable  (redirect_enable),
    .redirect_pc      (redirect_pc),
    .misaligned_fault (misaligned_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F00};
  endfunction

  // Instruction memory: acks after mem_delay waiting cycles.
  assign imem_ack   = imem_req && (wait_cnt >= mem_delay);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= 0;
      ack_count <= 0;
    end else if (imem_req && imem_ack) begin
      wait_cnt  <= 0;
      ack_count <= ack_count + 1;
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(negedge clock) begin : monitor
    logic [31:0] e;
    if (!reset && instruction_valid && decode_ready && !redirect_enable) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %h expected none", instruction_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", instruction_pc, e);
        check("pop_insn", instruction, mem_word(e));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic cyc();
    step();
    sample();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_enable = 1'b0;
    redirect_pc = 32'd0;
    step();
    step();
    exp_q.delete();
  endtask

  task automatic release_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic run_until_drained(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
      decode_ready = (exp_q.size() > 0);
      sample();
    end
    step();
    decode_ready = 1'b0;
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Zero-wait memory, decode always ready.
    mem_delay = 0;
    decode_ready = 1'b1;
    do_reset();
    sample();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instruction_valid, 0);
    check("rst_insn", instruction, 32'h0);
    check("rst_ipc", instruction_pc, 32'h0);
    check("rst_fault", misaligned_fault, 0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    release_reset();
    cyc();
    check("p1_c1_req", imem_req, 1);
    check("p1_c1_addr", imem_addr, 32'h0);
    check("p1_c1_valid", instruction_valid, 0);
    cyc();
    check("p1_c2_addr", imem_addr, 32'h4);
    check("p1_c2_valid", instruction_valid, 1);
    cyc();
    check("p1_c3_addr", imem_addr, 32'h8);
    cyc();
    check("p1_c4_addr", imem_addr, 32'hC);
    run_until_drained(40);

    // Backpressure: decode stalls for 6 cycles with a 2-deep FIFO.
    decode_ready = 1'b0;
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    release_reset();
    for (int i = 0; i < 6; i++) cyc();
    check("p2_acks", ack_count, 2);
    check("p2_req_full", imem_req, 0);
    check("p2_head_pc", instruction_pc, 32'h0);
    check("p2_head_valid", instruction_valid, 1);
    step();
    decode_ready = 1'b1;
    sample();
    cyc();
    check("p2_resume_req", imem_req, 1);
    check("p2_resume_addr", imem_addr, 32'h8);
    run_until_drained(40);

    // Slow memory with a redirect while the request is outstanding.
    mem_delay = 3;
    do_reset();
    exp_q = '{32'h100, 32'h104};
    release_reset();
    cyc();
    check("p3_c1_addr", imem_addr, 32'h0);
    step();
    redirect_enable = 1'b1;
    redirect_pc = 32'h100;
    sample();
    step();
    redirect_enable = 1'b0;
    sample();
    check("p3_hold_req", imem_req, 1);
    check("p3_hold_addr", imem_addr, 32'h0);
    cyc();
    check("p3_ack_addr", imem_addr, 32'h0);
    check("p3_ack", imem_ack, 1);
    cyc();
    check("p3_new_req", imem_req, 1);
    check("p3_new_addr", imem_addr, 32'h100);
    check("p3_no_valid", instruction_valid, 0);
    run_until_drained(60);

    // Redirect coinciding with the ack for 0x8.
    mem_delay = 0;
    decode_ready = 1'b1;
    do_reset();
    exp_q = '{32'h0, 32'h200, 32'h204};
    release_reset();
    cyc();
    cyc();
    step();
    redirect_enable = 1'b1;
    redirect_pc = 32'h200;
    sample();
    check("p4_coincide_addr", imem_addr, 32'h8);
    check("p4_coincide_ack", imem_ack, 1);
    step();
    redirect_enable = 1'b0;
    sample();
    check("p4_flushed_valid", instruction_valid, 0);
    check("p4_target_addr", imem_addr, 32'h200);
    check("p4_target_req", imem_req, 1);
    run_until_drained(40);

    // PC wraps past the top of the address space.
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    step();
    redirect_enable = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sample();
    step();
    redirect_enable = 1'b0;
    sample();
    check("p5_top_addr", imem_addr, 32'hFFFF_FFFC);
    check("p5_top_valid", instruction_valid, 0);
    cyc();
    check("p5_wrap_req", imem_req, 1);
    check("p5_wrap_addr", imem_addr, 32'h0);
    run_until_drained(40);

    // Misaligned redirect halts fetch until reset.
    step();
    redirect_enable = 1'b1;
    redirect_pc = 32'h102;
    sample();
    step();
    redirect_enable = 1'b0;
    sample();
    check("p6_fault", misaligned_fault, 1);
    check("p6_req", imem_req, 0);
    check("p6_valid", instruction_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      decode_ready = 1'b1;
      redirect_enable = (i == 1);
      redirect_pc = 32'h300;
      sample();
      check("p6_halt_req", imem_req, 0);
      check("p6_halt_valid", instruction_valid, 0);
    end
    step();
    redirect_enable = 1'b0;
    decode_ready = 1'b0;
    check("p6_fault_sticky", misaligned_fault, 1);
    do_reset();
    sample();
    check("p6_rst_fault", misaligned_fault, 0);
    exp_q = '{32'h0};
    release_reset();
    cyc();
    check("p6_restart_req", imem_req, 1);
    check("p6_restart_addr", imem_addr, 32'h0);
    run_until_drained(40);

    // Misaligned redirect while a slow request is pending.
    mem_delay = 3;
    do_reset();
    release_reset();
    cyc();
    step();
    redirect_enable = 1'b1;
    redirect_pc = 32'h6;
    sample();
    step();
    redirect_enable = 1'b0;
    sample();
    check("p7_fault", misaligned_fault, 1);
    check("p7_pending_req", imem_req, 1);
    check("p7_pending_addr", imem_addr, 32'h0);
    cyc();
    cyc();
    check("p7_halt_req", imem_req, 0);
    check("p7_halt_valid", instruction_valid, 0);
    cyc();
    check("p7_halt_req2", imem_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the rv32i core. Produces the `instruction` word consumed by the opcode decode stage.
- Owns the program counter and issues single-outstanding word reads to instruction memory.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, number of {pc, instruction} entries buffered toward decode; legal values 1..4.

Ports:
- clock, input, 1, single core clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high; sampled on the rising edge of clock.
- imem_req, output, 1, instruction read request.
- imem_addr, output, 32, word address of the read; bits [1:0] are always 0.
- imem_ack, input, 1, memory has accepted the request and returned data this cycle.
- imem_rdata, input, 32, instruction word; valid only when imem_ack=1.
- instruction, output, 32, FIFO head instruction to decode.
- instruction_pc, output, 32, PC of the FIFO head.
- instruction_valid, output, 1, FIFO head is valid.
- decode_ready, input, 1, decode consumes the head this cycle when instruction_valid=1.
- redirect_enable, input, 1, one-cycle pulse from branch/jal/jalr resolution.
- redirect_pc, input, 32, new fetch PC; valid when redirect_enable=1.
- misaligned_fault, output, 1, sticky flag: the redirect target was not word aligned.

Behaviour:
- Reset values:
  - pc=RESET_PC, FIFO count=0.
  - instruction_valid=0, instruction=0, instruction_pc=0.
  - imem_req=0, imem_addr=RESET_PC, misaligned_fault=0.
  - state=FETCH.
  - Reset mid-transaction abandons the request; an imem_ack arriving during or after reset is ignored.
- States:
  - FETCH: normal operation.
  - FLUSH: discard one pending response.
  - HALT: stopped after a fault.
- FETCH:
  - imem_req=1 and imem_addr=pc whenever count<FIFO_DEPTH.
  - Once raised, imem_req and imem_addr are held stable until imem_ack=1.
  - On imem_ack: push {pc, imem_rdata} into the FIFO, then pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0).
  - A new request may be issued in the cycle after an ack.
- Memory protocol:
  - Zero-wait memory may assert imem_ack in the same cycle as imem_req.
  - Latency from an ack to instruction_valid is 1 cycle.
  - With zero-wait memory and decode_ready=1, throughput is 1 instruction per cycle.
- Decode handshake:
  - instruction, instruction_pc and instruction_valid come from registered FIFO storage, with no combinational path from imem_rdata.
  - A pop occurs when instruction_valid & decode_ready.
  - Push and pop in the same cycle leave count unchanged.
  - While the FIFO is full, imem_req stays 0 until a pop frees a slot; the request rises in the cycle after that pop.
  - The head is held stable while instruction_valid=1 and decode_ready=0.
- Redirect with redirect_pc[1:0]==0 takes priority over push and pop in that cycle:
  - FIFO flushed; count=0 and instruction_valid=0 in the next cycle.
  - pc<=redirect_pc.
  - If imem_req=1 and imem_ack=0 in the redirect cycle, go to FLUSH.
  - Otherwise stay in FETCH and request redirect_pc next cycle.
  - An imem_ack coinciding with the redirect is discarded.
- FLUSH:
  - Keeps imem_req=1 with the old imem_addr until imem_ack, then discards the data and returns to FETCH.
  - The request to the redirect target is issued in the following cycle.
  - A second redirect during FLUSH updates pc and stays in FLUSH.
- Redirect with redirect_pc[1:0]!=0:
  - misaligned_fault<=1 (sticky until reset).
  - FIFO flushed; pc unchanged.
  - Go to HALT; if a request is pending, its ack is still awaited and discarded first.
- HALT:
  - imem_req=0 and instruction_valid=0.
  - Further redirects are ignored.
  - Only reset exits HALT.

Test Plan:
- Reset then zero-wait memory (ack=req), decode_ready=1 → first imem_req in the first cycle after reset deasserts, addr 0x0; instruction_valid one cycle after each ack; pcs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- decode_ready=0 for 6 cycles, FIFO_DEPTH=2 → exactly 2 acks accepted, then imem_req=0; the head holds pc 0x0; raising ready resumes fetch at 0x8 with no loss or duplication.
- Memory ack delayed 3 cycles, redirect_pc=0x100 during the wait → old addr held until ack, that data dropped, next imem_addr=0x100, first valid instruction_pc=0x100.
- Redirect in the same cycle as imem_ack for addr 0x8 → word 0x8 never reaches decode; FIFO empty next cycle; fetch resumes at the redirect target.
- pc=0xFFFF_FFFC, ack → next imem_addr=0x0000_0000.
- redirect_pc=0x102 → misaligned_fault=1 next cycle; imem_req stays 0 and instruction_valid stays 0 until reset; after reset, fault=0 and fetch restarts at RESET_PC.
